// File: rtl/safe_sdram.sv
// Single-bank-at-a-time SDRAM command layer: maps one abstract command per cycle onto
// SDRAM pins, suppresses timing-illegal commands, and returns tagged read data.
package safe_sdram_pkg;
  typedef enum logic [3:0] {
    CMD_NOOP           = 4'd0,
    CMD_ACTIVATE       = 4'd1,
    CMD_READ           = 4'd2,
    CMD_READA          = 4'd3,
    CMD_WRITE          = 4'd4,
    CMD_WRITEA         = 4'd5,
    CMD_AREFRESH       = 4'd6,
    CMD_PRECHARGE_BANK = 4'd7,
    CMD_PRECHARGE_ALL  = 4'd8,
    CMD_SET_MODE_REG   = 4'd9
  } command_e;
endpackage

module safe_sdram
  import safe_sdram_pkg::*;
#(
  parameter int unsigned T_RCD       = 2,
  parameter int unsigned T_RAS       = 5,
  parameter int unsigned T_RP        = 2,
  parameter int unsigned T_DPL       = 2,
  parameter int unsigned T_RFC       = 8,
  parameter int unsigned T_MRD       = 2,
  parameter int unsigned CAS_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  command_e    command_i,
  input  logic [12:0] addr_i,
  input  logic [1:0]  bank_sel_i,
  input  logic [1:0]  write_mask_i,
  input  logic [15:0] wdata_i,
  output logic        command_ready_o,
  output logic        precharge_ready_o,
  output logic        write_ready_o,
  output logic        row_open_o,
  output logic        read_valid_o,
  output logic [24:0] raddr_o,
  output logic [15:0] rdata_o,
  inout  wire  [15:0] dram_dq_io,
  output logic [12:0] dram_addr_o,
  output logic [1:0]  dram_ba_o,
  output logic        dram_cas_n_o,
  output logic        dram_cke_o,
  output logic        dram_clk_o,
  output logic        dram_cs_n_o,
  output logic        dram_ldqm_o,
  output logic        dram_ras_n_o,
  output logic        dram_udqm_o,
  output logic        dram_we_n_o
);

  // Burst length 1, sequential, CAS latency in bits [6:4].
  localparam logic [12:0] MODE_REG = {6'd0, 3'(CAS_LATENCY), 1'b0, 3'd0};
  localparam logic [3:0]  T_TURN   = 4'd4;

  logic [3:0]  cmd_cnt_q, cmd_cnt_d, pre_cnt_q, pre_cnt_d;
  logic [3:0]  wr_cnt_q, wr_cnt_d, wa_cnt_q, wa_cnt_d;
  logic        command_ready_q, precharge_ready_q, write_ready_q;
  logic        row_open_q, row_open_d;
  logic [1:0]  bank_q, bank_d;
  logic [12:0] row_q, row_d;
  logic        rd0_v_q, rd0_v_d, rd1_v_q;
  logic [24:0] rd0_a_q, rd0_a_d, rd1_a_q;
  logic        read_valid_q;
  logic [24:0] raddr_q;
  logic [15:0] rdata_q;
  logic        legal;
  command_e    eff_cmd;
  logic        dq_oe;

  // Legality filter: anything the timers forbid degrades to NOOP.
  always_comb begin
    legal = 1'b0;
    case (command_i)
      CMD_NOOP:                                      legal = 1'b1;
      CMD_ACTIVATE, CMD_AREFRESH, CMD_SET_MODE_REG:  legal = command_ready_q & ~row_open_q;
      CMD_READ:                                      legal = command_ready_q & row_open_q;
      CMD_WRITE:          legal = command_ready_q & write_ready_q & row_open_q;
      CMD_READA, CMD_PRECHARGE_BANK:                 legal = command_ready_q & precharge_ready_q;
      CMD_PRECHARGE_ALL:  legal = command_ready_q & (precharge_ready_q | ~row_open_q);
      CMD_WRITEA:         legal = command_ready_q & precharge_ready_q & write_ready_q;
      default:                                       legal = 1'b0;
    endcase
    if (legal) begin
      eff_cmd = command_i;
    end else begin
      eff_cmd = CMD_NOOP;
    end
  end

  // Pin encoding of the filtered command.
  always_comb begin
    dram_cs_n_o  = 1'b0;
    dram_ras_n_o = 1'b1;
    dram_cas_n_o = 1'b1;
    dram_we_n_o  = 1'b1;
    dram_addr_o  = 13'd0;
    dram_ba_o    = 2'd0;
    dq_oe        = 1'b0;
    dram_ldqm_o  = 1'b0;
    dram_udqm_o  = 1'b0;
    case (eff_cmd)
      CMD_ACTIVATE: begin
        dram_ras_n_o = 1'b0;
        dram_addr_o  = addr_i;
        dram_ba_o    = bank_sel_i;
      end
      CMD_READ, CMD_READA: begin
        dram_cas_n_o = 1'b0;
        dram_addr_o  = {2'b00, (eff_cmd == CMD_READA), addr_i[9:0]};
        dram_ba_o    = bank_q;
      end
      CMD_WRITE, CMD_WRITEA: begin
        dram_cas_n_o = 1'b0;
        dram_we_n_o  = 1'b0;
        dram_addr_o  = {2'b00, (eff_cmd == CMD_WRITEA), addr_i[9:0]};
        dram_ba_o    = bank_q;
        dq_oe        = 1'b1;
        dram_ldqm_o  = ~write_mask_i[0];
        dram_udqm_o  = ~write_mask_i[1];
      end
      CMD_AREFRESH: begin
        dram_ras_n_o = 1'b0;
        dram_cas_n_o = 1'b0;
      end
      CMD_PRECHARGE_BANK: begin
        dram_ras_n_o = 1'b0;
        dram_we_n_o  = 1'b0;
        dram_ba_o    = bank_sel_i;
      end
      CMD_PRECHARGE_ALL: begin
        dram_ras_n_o = 1'b0;
        dram_we_n_o  = 1'b0;
        dram_addr_o  = 13'h0400;
      end
      CMD_SET_MODE_REG: begin
        dram_ras_n_o = 1'b0;
        dram_cas_n_o = 1'b0;
        dram_we_n_o  = 1'b0;
        dram_addr_o  = MODE_REG;
      end
      default: begin
        dram_cs_n_o = 1'b0;
      end
    endcase
  end

  // Timer and row-state next-state logic.
  always_comb begin
    cmd_cnt_d  = (cmd_cnt_q == 4'd0) ? 4'd0 : cmd_cnt_q - 4'd1;
    pre_cnt_d  = (pre_cnt_q == 4'd0) ? 4'd0 : pre_cnt_q - 4'd1;
    wr_cnt_d   = (wr_cnt_q  == 4'd0) ? 4'd0 : wr_cnt_q  - 4'd1;
    wa_cnt_d   = (wa_cnt_q  == 4'd0) ? 4'd0 : wa_cnt_q  - 4'd1;
    row_open_d = row_open_q;
    bank_d     = bank_q;
    row_d      = row_q;
    rd0_v_d    = 1'b0;
    rd0_a_d    = {bank_q, row_q, addr_i[9:0]};
    // The auto-precharge of a WRITEA closes the row once write recovery ends.
    if (wa_cnt_q == 4'd1) begin
      row_open_d = 1'b0;
    end else begin
      row_open_d = row_open_q;
    end
    case (eff_cmd)
      CMD_ACTIVATE: begin
        bank_d     = bank_sel_i;
        row_d      = addr_i;
        row_open_d = 1'b1;
        cmd_cnt_d  = 4'(T_RCD);
        pre_cnt_d  = 4'(T_RAS);
      end
      CMD_READ: begin
        rd0_v_d  = 1'b1;
        wr_cnt_d = T_TURN;
      end
      CMD_READA: begin
        rd0_v_d    = 1'b1;
        wr_cnt_d   = T_TURN;
        row_open_d = 1'b0;
        cmd_cnt_d  = 4'(T_RP);
      end
      CMD_WRITE: begin
        if (pre_cnt_q <= 4'(T_DPL)) begin
          pre_cnt_d = 4'(T_DPL);
        end else begin
          pre_cnt_d = pre_cnt_q - 4'd1;
        end
      end
      CMD_WRITEA: begin
        pre_cnt_d = 4'(T_DPL);
        wa_cnt_d  = 4'(T_DPL);
        cmd_cnt_d = 4'(T_DPL + T_RP);
      end
      CMD_AREFRESH:     cmd_cnt_d = 4'(T_RFC);
      CMD_SET_MODE_REG: cmd_cnt_d = 4'(T_MRD);
      CMD_PRECHARGE_BANK, CMD_PRECHARGE_ALL: begin
        row_open_d = 1'b0;
        cmd_cnt_d  = 4'(T_RP);
      end
      default: begin
        rd0_v_d = 1'b0;
      end
    endcase
  end

  // State registers, read-return pipeline and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_cnt_q         <= 4'd0;
      pre_cnt_q         <= 4'd0;
      wr_cnt_q          <= 4'd0;
      wa_cnt_q          <= 4'd0;
      row_open_q        <= 1'b0;
      bank_q            <= 2'd0;
      row_q             <= 13'd0;
      command_ready_q   <= 1'b1;
      precharge_ready_q <= 1'b0;
      write_ready_q     <= 1'b1;
      rd0_v_q           <= 1'b0;
      rd0_a_q           <= 25'd0;
      rd1_v_q           <= 1'b0;
      rd1_a_q           <= 25'd0;
      read_valid_q      <= 1'b0;
      raddr_q           <= 25'd0;
      rdata_q           <= 16'd0;
    end else begin
      cmd_cnt_q         <= cmd_cnt_d;
      pre_cnt_q         <= pre_cnt_d;
      wr_cnt_q          <= wr_cnt_d;
      wa_cnt_q          <= wa_cnt_d;
      row_open_q        <= row_open_d;
      bank_q            <= bank_d;
      row_q             <= row_d;
      command_ready_q   <= (cmd_cnt_d == 4'd0);
      precharge_ready_q <= row_open_d & (pre_cnt_d == 4'd0);
      write_ready_q     <= (wr_cnt_d == 4'd0);
      rd0_v_q           <= rd0_v_d;
      rd0_a_q           <= rd0_a_d;
      rd1_v_q           <= rd0_v_q;
      rd1_a_q           <= rd0_a_q;
      read_valid_q      <= rd1_v_q;
      if (rd1_v_q) begin
        raddr_q <= rd1_a_q;
        rdata_q <= dram_dq_io;
      end
    end
  end

  assign dram_dq_io        = dq_oe ? wdata_i : 16'hzzzz;
  assign dram_cke_o        = 1'b1;
  assign dram_clk_o        = ~clk;
  assign command_ready_o   = command_ready_q;
  assign precharge_ready_o = precharge_ready_q;
  assign write_ready_o     = write_ready_q;
  assign row_open_o        = row_open_q;
  assign read_valid_o      = read_valid_q;
  assign raddr_o           = raddr_q;
  assign rdata_o           = rdata_q;

endmodule

// File: tb/tb_safe_sdram.sv
// Directed bench for safe_sdram: pin encodings, ready timing and read return.
module tb_safe_sdram;
  import safe_sdram_pkg::*;

  logic clk, rst;
  command_e command;
  logic [12:0] addr;
  logic [1:0] bank_sel, wmask;
  logic [15:0] wdata;
  logic cmd_rdy, pre_rdy, wr_rdy, row_open, rvalid;
  logic [24:0] raddr;
  logic [15:0] rdata;
  wire  [15:0] dq;
  logic [12:0] d_addr;
  logic [1:0] d_ba;
  logic cas_n, cke, dclk, cs_n, ldqm, ras_n, udqm, we_n;
  logic dq_en;
  logic [15:0] dq_val;
  int n_cmp, n_bad;
  logic [14:0] br;

  assign dq = dq_en ? dq_val : 16'hzzzz;
  wire [4:0] pins = {cke, cs_n, ras_n, cas_n, we_n};

  safe_sdram dut (
    .clk(clk), .rst(rst), .command_i(command), .addr_i(addr), .bank_sel_i(bank_sel),
    .write_mask_i(wmask), .wdata_i(wdata), .command_ready_o(cmd_rdy),
    .precharge_ready_o(pre_rdy), .write_ready_o(wr_rdy), .row_open_o(row_open),
    .read_valid_o(rvalid), .raddr_o(raddr), .rdata_o(rdata), .dram_dq_io(dq),
    .dram_addr_o(d_addr), .dram_ba_o(d_ba), .dram_cas_n_o(cas_n), .dram_cke_o(cke),
    .dram_clk_o(dclk), .dram_cs_n_o(cs_n), .dram_ldqm_o(ldqm), .dram_ras_n_o(ras_n),
    .dram_udqm_o(udqm), .dram_we_n_o(we_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input command_e c, input logic [12:0] a, input logic [1:0] b,
                       input logic [1:0] m, input logic [15:0] d);
    command = c; addr = a; bank_sel = b; wmask = m; wdata = d;
    #1;
  endtask

  task automatic nop();
    command = CMD_NOOP;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; dq_en = 1'b0; dq_val = 16'h0000;
    drive(CMD_NOOP, 13'd0, 2'd0, 2'b11, 16'h0000);
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (cmd_rdy !== 1'b1) begin n_bad++; $display("FAIL rst_cmd_ready got %0h want 1", cmd_rdy); end
    n_cmp++; if (pre_rdy !== 1'b0) begin n_bad++; $display("FAIL rst_pre_ready got %0h want 0", pre_rdy); end
    n_cmp++; if (wr_rdy !== 1'b1) begin n_bad++; $display("FAIL rst_wr_ready got %0h want 1", wr_rdy); end
    n_cmp++; if (row_open !== 1'b0) begin n_bad++; $display("FAIL rst_row_open got %0h want 0", row_open); end
    n_cmp++; if ({rvalid, raddr, rdata} !== 42'd0) begin n_bad++; $display("FAIL rst_read_out got %0h/%0h/%0h want 0", rvalid, raddr, rdata); end
    n_cmp++; if ({pins, ldqm, udqm} !== 7'b1011100) begin n_bad++; $display("FAIL nop_pins got %b want 1011100", {pins, ldqm, udqm}); end
    rst = 1'b0;
    tick();
    drive(CMD_READ, 13'd5, 2'd0, 2'b11, 16'h0000);
    n_cmp++; if (pins !== 5'b10111) begin n_bad++; $display("FAIL read_closed_suppressed got %b want 10111", pins); end
    tick(); nop();
    n_cmp++; if (wr_rdy !== 1'b1) begin n_bad++; $display("FAIL read_closed_no_effect got %0h want 1", wr_rdy); end
  endtask

  task automatic test_encodings();
    drive(CMD_SET_MODE_REG, 13'h1FFF, 2'd3, 2'b11, 16'h0000);
    n_cmp++; if ({pins, d_addr, d_ba} !== {5'b10000, 13'h020, 2'd0}) begin n_bad++; $display("FAIL mrs_pins got %b/%h/%0d want 10000/020/0", pins, d_addr, d_ba); end
    tick(); nop();
    n_cmp++; if (cmd_rdy !== 1'b0) begin n_bad++; $display("FAIL mrs_busy0 got %0h want 0", cmd_rdy); end
    tick();
    n_cmp++; if (cmd_rdy !== 1'b0) begin n_bad++; $display("FAIL mrs_busy1 got %0h want 0", cmd_rdy); end
    tick();
    n_cmp++; if (cmd_rdy !== 1'b1) begin n_bad++; $display("FAIL mrs_done got %0h want 1", cmd_rdy); end
    drive(CMD_AREFRESH, 13'd0, 2'd0, 2'b11, 16'h0000);
    n_cmp++; if (pins !== 5'b10001) begin n_bad++; $display("FAIL aref_pins got %b want 10001", pins); end
    tick(); nop();
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (cmd_rdy !== 1'b0) begin n_bad++; $display("FAIL aref_busy%0d got %0h want 0", i, cmd_rdy); end
      tick();
    end
    n_cmp++; if (cmd_rdy !== 1'b1) begin n_bad++; $display("FAIL aref_done got %0h want 1", cmd_rdy); end
    drive(CMD_PRECHARGE_ALL, 13'd0, 2'd2, 2'b11, 16'h0000);
    n_cmp++; if ({pins, d_addr} !== {5'b10010, 13'h0400}) begin n_bad++; $display("FAIL prea_pins got %b/%h want 10010/0400", pins, d_addr); end
    tick(); nop();
    n_cmp++; if ({cmd_rdy, row_open} !== 2'b00) begin n_bad++; $display("FAIL prea_busy got %b want 00", {cmd_rdy, row_open}); end
    tick(); tick();
    n_cmp++; if (cmd_rdy !== 1'b1) begin n_bad++; $display("FAIL prea_done got %0h want 1", cmd_rdy); end
  endtask

  task automatic test_activate();
    br = 15'd9999;
    drive(CMD_ACTIVATE, br[12:0], br[14:13], 2'b11, 16'h0000);
    n_cmp++; if ({pins, d_addr, d_ba} !== {5'b10011, 13'd1807, 2'd1}) begin n_bad++; $display("FAIL act_pins got %b/%0d/%0d want 10011/1807/1", pins, d_addr, d_ba); end
    tick();
    n_cmp++; if ({cmd_rdy, row_open, pre_rdy} !== 3'b010) begin n_bad++; $display("FAIL act_e0 got %b want 010", {cmd_rdy, row_open, pre_rdy}); end
    drive(CMD_READ, 13'd5, 2'd0, 2'b11, 16'h0000);
    n_cmp++; if (pins !== 5'b10111) begin n_bad++; $display("FAIL read_in_trcd_suppressed got %b want 10111", pins); end
    tick(); nop();
    n_cmp++; if (cmd_rdy !== 1'b0) begin n_bad++; $display("FAIL act_e1 got %0h want 0", cmd_rdy); end
    tick();
    n_cmp++; if ({cmd_rdy, row_open} !== 2'b11) begin n_bad++; $display("FAIL act_ready got %b want 11", {cmd_rdy, row_open}); end
  endtask

  task automatic test_read();
    dq_en = 1'b1; dq_val = 16'h1234;
    drive(CMD_READ, 13'd720, 2'd0, 2'b11, 16'h0000);
    n_cmp++; if ({pins, d_addr, d_ba} !== {5'b10101, 13'd720, 2'd1}) begin n_bad++; $display("FAIL read_pins got %b/%0d/%0d want 10101/720/1", pins, d_addr, d_ba); end
    tick(); nop();
    n_cmp++; if ({rvalid, wr_rdy} !== 2'b00) begin n_bad++; $display("FAIL read_e0 got %b want 00", {rvalid, wr_rdy}); end
    tick();
    n_cmp++; if ({rvalid, wr_rdy} !== 2'b00) begin n_bad++; $display("FAIL read_e1 got %b want 00", {rvalid, wr_rdy}); end
    tick();
    n_cmp++; if ({rvalid, wr_rdy, pre_rdy} !== 3'b101) begin n_bad++; $display("FAIL read_e2 got %b want 101", {rvalid, wr_rdy, pre_rdy}); end
    n_cmp++; if ({raddr, rdata} !== {br, 10'd720, 16'h1234}) begin n_bad++; $display("FAIL read_data got %0d/%h want %0d/1234", raddr, rdata, {br, 10'd720}); end
    tick();
    n_cmp++; if ({rvalid, wr_rdy} !== 2'b00) begin n_bad++; $display("FAIL read_e3 got %b want 00", {rvalid, wr_rdy}); end
    tick();
    n_cmp++; if (wr_rdy !== 1'b1) begin n_bad++; $display("FAIL read_turn_done got %0h want 1", wr_rdy); end
    dq_en = 1'b0;
  endtask

  task automatic test_write();
    drive(CMD_WRITE, 13'd299, 2'd0, 2'b11, 16'hDEAD);
    n_cmp++; if ({pins, d_addr, ldqm, udqm} !== {5'b10100, 13'd299, 2'b00}) begin n_bad++; $display("FAIL write_pins got %b/%0d/%b want 10100/299/00", pins, d_addr, {ldqm, udqm}); end
    n_cmp++; if (dq !== 16'hDEAD) begin n_bad++; $display("FAIL write_dq got %h want dead", dq); end
    tick(); nop();
    n_cmp++; if (pre_rdy !== 1'b0) begin n_bad++; $display("FAIL write_dpl0 got %0h want 0", pre_rdy); end
    tick();
    n_cmp++; if (pre_rdy !== 1'b0) begin n_bad++; $display("FAIL write_dpl1 got %0h want 0", pre_rdy); end
    tick();
    n_cmp++; if ({pre_rdy, row_open} !== 2'b11) begin n_bad++; $display("FAIL write_dpl_done got %b want 11", {pre_rdy, row_open}); end
  endtask

  task automatic test_reada();
    dq_en = 1'b1; dq_val = 16'hC0DE;
    drive(CMD_READA, 13'd185, 2'd0, 2'b11, 16'h0000);
    n_cmp++; if ({pins, d_addr} !== {5'b10101, 13'd1209}) begin n_bad++; $display("FAIL reada_pins got %b/%h want 10101/4b9", pins, d_addr); end
    tick(); nop();
    n_cmp++; if ({cmd_rdy, row_open, pre_rdy} !== 3'b000) begin n_bad++; $display("FAIL reada_e0 got %b want 000", {cmd_rdy, row_open, pre_rdy}); end
    tick();
    n_cmp++; if (cmd_rdy !== 1'b0) begin n_bad++; $display("FAIL reada_e1 got %0h want 0", cmd_rdy); end
    tick();
    n_cmp++; if ({cmd_rdy, row_open, rvalid} !== 3'b101) begin n_bad++; $display("FAIL reada_e2 got %b want 101", {cmd_rdy, row_open, rvalid}); end
    n_cmp++; if ({raddr, rdata} !== {br, 10'd185, 16'hC0DE}) begin n_bad++; $display("FAIL reada_data got %0d/%h want %0d/c0de", raddr, rdata, {br, 10'd185}); end
    dq_en = 1'b0;
  endtask

  task automatic test_writea();
    br = 15'd4444;
    drive(CMD_ACTIVATE, br[12:0], br[14:13], 2'b11, 16'h0000);
    n_cmp++; if ({pins, d_addr, d_ba} !== {5'b10011, 13'd4444, 2'd0}) begin n_bad++; $display("FAIL act2_pins got %b/%0d/%0d want 10011/4444/0", pins, d_addr, d_ba); end
    tick(); nop();
    repeat (4) tick();
    n_cmp++; if (pre_rdy !== 1'b0) begin n_bad++; $display("FAIL tras_edge got %0h want 0", pre_rdy); end
    tick();
    n_cmp++; if ({pre_rdy, wr_rdy} !== 2'b11) begin n_bad++; $display("FAIL tras_done got %b want 11", {pre_rdy, wr_rdy}); end
    drive(CMD_WRITEA, 13'd7, 2'd3, 2'b10, 16'hBEEF);
    n_cmp++; if ({pins, d_addr, d_ba, ldqm, udqm} !== {5'b10100, 13'h0407, 2'd0, 2'b10}) begin n_bad++; $display("FAIL writea_pins got %b/%h/%0d/%b want 10100/0407/0/10", pins, d_addr, d_ba, {ldqm, udqm}); end
    n_cmp++; if (dq !== 16'hBEEF) begin n_bad++; $display("FAIL writea_dq got %h want beef", dq); end
    tick(); nop();
    n_cmp++; if ({cmd_rdy, row_open, ldqm} !== 3'b010) begin n_bad++; $display("FAIL writea_e0 got %b want 010", {cmd_rdy, row_open, ldqm}); end
    tick();
    n_cmp++; if ({cmd_rdy, row_open} !== 2'b01) begin n_bad++; $display("FAIL writea_e1 got %b want 01", {cmd_rdy, row_open}); end
    tick();
    n_cmp++; if ({cmd_rdy, row_open} !== 2'b00) begin n_bad++; $display("FAIL writea_e2 got %b want 00", {cmd_rdy, row_open}); end
    tick();
    n_cmp++; if ({cmd_rdy, row_open} !== 2'b00) begin n_bad++; $display("FAIL writea_e3 got %b want 00", {cmd_rdy, row_open}); end
    tick();
    n_cmp++; if ({cmd_rdy, pre_rdy, row_open} !== 3'b100) begin n_bad++; $display("FAIL writea_done got %b want 100", {cmd_rdy, pre_rdy, row_open}); end
  endtask

  task automatic test_back_to_back();
    br = 15'd20000;
    drive(CMD_ACTIVATE, br[12:0], br[14:13], 2'b11, 16'h0000);
    tick(); nop();
    tick(); tick();
    dq_en = 1'b1; dq_val = 16'h1111;
    drive(CMD_READ, 13'd1, 2'd0, 2'b11, 16'h0000);
    tick();
    drive(CMD_READ, 13'd2, 2'd0, 2'b11, 16'h0000);
    n_cmp++; if ({pins, d_ba} !== {5'b10101, 2'd2}) begin n_bad++; $display("FAIL b2b_second_pins got %b/%0d want 10101/2", pins, d_ba); end
    tick(); nop();
    n_cmp++; if (rvalid !== 1'b0) begin n_bad++; $display("FAIL b2b_e1 got %0h want 0", rvalid); end
    tick();
    n_cmp++; if ({rvalid, raddr, rdata} !== {1'b1, br, 10'd1, 16'h1111}) begin n_bad++; $display("FAIL b2b_first got %0h/%0d/%h want 1/%0d/1111", rvalid, raddr, rdata, {br, 10'd1}); end
    dq_val = 16'h2222;
    drive(CMD_WRITE, 13'd3, 2'd0, 2'b11, 16'h5555);
    n_cmp++; if (pins !== 5'b10111) begin n_bad++; $display("FAIL write_turn_suppressed got %b want 10111", pins); end
    tick(); nop();
    n_cmp++; if ({rvalid, raddr, rdata} !== {1'b1, br, 10'd2, 16'h2222}) begin n_bad++; $display("FAIL b2b_second got %0h/%0d/%h want 1/%0d/2222", rvalid, raddr, rdata, {br, 10'd2}); end
    n_cmp++; if ({wr_rdy, pre_rdy} !== 2'b01) begin n_bad++; $display("FAIL b2b_e3_ready got %b want 01", {wr_rdy, pre_rdy}); end
    tick();
    n_cmp++; if ({rvalid, wr_rdy} !== 2'b00) begin n_bad++; $display("FAIL b2b_e4 got %b want 00", {rvalid, wr_rdy}); end
    tick();
    n_cmp++; if (wr_rdy !== 1'b1) begin n_bad++; $display("FAIL b2b_turn_done got %0h want 1", wr_rdy); end
    dq_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    drive(CMD_PRECHARGE_BANK, 13'd0, 2'd2, 2'b11, 16'h0000);
    n_cmp++; if ({pins, d_addr, d_ba} !== {5'b10010, 13'd0, 2'd2}) begin n_bad++; $display("FAIL preb_pins got %b/%h/%0d want 10010/0000/2", pins, d_addr, d_ba); end
    tick(); nop();
    n_cmp++; if ({cmd_rdy, row_open} !== 2'b00) begin n_bad++; $display("FAIL preb_e0 got %b want 00", {cmd_rdy, row_open}); end
    tick(); tick();
    drive(CMD_AREFRESH, 13'd0, 2'd0, 2'b11, 16'h0000);
    tick(); nop();
    n_cmp++; if (cmd_rdy !== 1'b0) begin n_bad++; $display("FAIL aref2_busy got %0h want 0", cmd_rdy); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({cmd_rdy, pre_rdy, wr_rdy, row_open, rvalid} !== 5'b10100) begin n_bad++; $display("FAIL midrst_flags got %b want 10100", {cmd_rdy, pre_rdy, wr_rdy, row_open, rvalid}); end
    n_cmp++; if ({raddr, rdata} !== 41'd0) begin n_bad++; $display("FAIL midrst_data got %0h/%0h want 0/0", raddr, rdata); end
    @(negedge clk);
    rst = 1'b0;
    tick();
    n_cmp++; if (cmd_rdy !== 1'b1) begin n_bad++; $display("FAIL midrst_timer_cleared got %0h want 1", cmd_rdy); end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b1;
    test_reset();
    test_encodings();
    test_activate();
    test_read();
    test_write();
    test_reada();
    test_writea();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
